// File: rtl/otter_intr_pkg.sv
// otter_intr_pkg
//   Shared types and default sizing for the OTTER button interrupt
//   controller (button_intr_ctrl and its round-robin picker rr_pick).
//   STATES    : controller FSM encoding
//   N_SRC_DEF : default number of request sources (2..8)
//   GAP_CLKS_DEF : default quiet clocks between ACK and the next grant (1..255)
package otter_intr_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ARB    = 2'd1,
    ST_ASSERT = 2'd2,
    ST_GAP    = 2'd3
  } STATES;

  localparam int unsigned N_SRC_DEF    = 4;
  localparam int unsigned GAP_CLKS_DEF = 4;

  // Index width for a source count, never narrower than one bit.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/button_intr_ctrl_rr_pick.sv
// rr_pick
//   Combinational round-robin selector. Searches req starting at
//   last+1 and wrapping modulo N_SRC; the first set bit wins.
//   Ports:
//     req   in  N_SRC  request vector (already masked by the caller)
//     last  in  IW     index of the most recently served source
//     valid out 1      at least one request present
//     idx   out IW     winning index (0 when valid=0)
module rr_pick
  import otter_intr_pkg::*;
#(
  parameter int unsigned N_SRC = N_SRC_DEF,
  parameter int unsigned IW    = idx_width(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IW-1:0]    last,
  output logic             valid,
  output logic [IW-1:0]    idx
);

  int unsigned cand;

  // k runs 1..N_SRC so that the last-served source is examined last.
  always_comb begin
    valid = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int unsigned k = 1; k <= N_SRC; k++) begin
      cand = (32'(last) + k) % N_SRC;
      if (!valid && req[cand]) begin
        valid = 1'b1;
        idx   = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/button_intr_ctrl.sv
// button_intr_ctrl
//   Shares the OTTER's single INTR pin among N_SRC debounced button
//   one-shots. Each rising PULSE edge latches a pending request; one
//   pending source is granted round-robin and INTR is held until the CPU
//   strobes ACK, after which INTR stays low for GAP_CLKS clocks.
//   Ports:
//     CLK      in   1       system clock
//     RST      in   1       synchronous, active-high reset
//     PULSE    in   N_SRC   one-shot request inputs
//     ACK      in   1       CPU acknowledge strobe (honoured only while INTR=1)
//     INTR     out  1       interrupt request to the MCU
//     SRC_ID   out  IW      granted source index, valid while INTR=1
//     PENDING  out  N_SRC   latched, unserviced requests
//     OVF      out  N_SRC   sticky: repeat press while already pending
//     MASK_WE  in   1       mask write strobe        (INTR_MASK_EN only)
//     MASK_WD  in   N_SRC   mask write data, 1=on    (INTR_MASK_EN only)
//   Build option: define INTR_MASK_EN to add the per-source enable mask.
module button_intr_ctrl
  import otter_intr_pkg::*;
#(
  parameter int unsigned N_SRC    = N_SRC_DEF,
  parameter int unsigned GAP_CLKS = GAP_CLKS_DEF,
  parameter int unsigned IW       = idx_width(N_SRC)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [N_SRC-1:0] PULSE,
  input  logic             ACK,
  output logic             INTR,
  output logic [IW-1:0]    SRC_ID,
  output logic [N_SRC-1:0] PENDING,
  output logic [N_SRC-1:0] OVF
`ifdef INTR_MASK_EN
  ,
  input  logic             MASK_WE,
  input  logic [N_SRC-1:0] MASK_WD
`endif
);

  STATES            state_q, state_d;
  logic [N_SRC-1:0] pulse_q, pulse_d;
  logic [N_SRC-1:0] pending_q, pending_d;
  logic [N_SRC-1:0] ovf_q, ovf_d;
  logic [IW-1:0]    src_id_q, src_id_d;
  logic [IW-1:0]    last_q, last_d;
  logic [7:0]       count_q, count_d;

  logic [N_SRC-1:0] rise;
  logic [N_SRC-1:0] clr;
  logic [N_SRC-1:0] mask;
  logic [N_SRC-1:0] eligible;
  logic             ack_fire;
  logic             pick_valid;
  logic [IW-1:0]    pick_idx;

`ifdef INTR_MASK_EN
  logic [N_SRC-1:0] mask_q, mask_d;

  always_comb begin
    mask_d = mask_q;
    if (MASK_WE) mask_d = MASK_WD;
  end

  always_ff @(posedge CLK) begin
    if (RST) mask_q <= '1;
    else     mask_q <= mask_d;
  end

  assign mask = mask_q;
`else
  assign mask = '1;
`endif

  assign eligible = pending_q & mask;
  assign ack_fire = (state_q == ST_ASSERT) && ACK;

  rr_pick #(
    .N_SRC (N_SRC),
    .IW    (IW)
  ) u_pick (
    .req   (eligible),
    .last  (last_q),
    .valid (pick_valid),
    .idx   (pick_idx)
  );

  // Request flags. The ACK clear is applied before the new rise is OR'd
  // in so a same-cycle press on the acknowledged source stays pending,
  // while its OVF is still cleared by the ACK.
  always_comb begin
    pulse_d = PULSE;
    rise    = PULSE & ~pulse_q;
    clr     = '0;
    if (ack_fire) clr[src_id_q] = 1'b1;
    pending_d = (pending_q & ~clr) | rise;
    ovf_d     = (ovf_q | (rise & pending_q)) & ~clr;
  end

  always_comb begin
    state_d  = state_q;
    src_id_d = src_id_q;
    last_d   = last_q;
    count_d  = count_q;
    unique case (state_q)
      ST_IDLE: begin
        if (|eligible) state_d = ST_ARB;
      end
      ST_ARB: begin
        if (pick_valid) begin
          src_id_d = pick_idx;
          state_d  = ST_ASSERT;
        end else begin
          state_d  = ST_IDLE;
        end
      end
      ST_ASSERT: begin
        if (ACK) begin
          last_d  = src_id_q;
          count_d = '0;
          state_d = ST_GAP;
        end
      end
      ST_GAP: begin
        count_d = count_q + 8'd1;
        if (count_q == 8'(GAP_CLKS - 1)) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= ST_IDLE;
      pulse_q   <= '0;
      pending_q <= '0;
      ovf_q     <= '0;
      src_id_q  <= '0;
      last_q    <= IW'(N_SRC - 1);
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pulse_q   <= pulse_d;
      pending_q <= pending_d;
      ovf_q     <= ovf_d;
      src_id_q  <= src_id_d;
      last_q    <= last_d;
      count_q   <= count_d;
    end
  end

  assign INTR    = (state_q == ST_ASSERT);
  assign SRC_ID  = src_id_q;
  assign PENDING = pending_q;
  assign OVF     = ovf_q;

endmodule
